// File: rtl/keysw_pkg.sv
// rtl/keysw_pkg.sv - shared constants and helpers for the KEY/SW input peripheral
// Purpose: register addresses, CTRL bit positions, default debounce length and
//          the CTRL read-word builder used by keysw_io_ctrl.
// Ports:   none (package).
package keysw_pkg;

  localparam logic [31:0] KEYSW_ADDR_KDATA = 32'hF0000010;
  localparam logic [31:0] KEYSW_ADDR_SDATA = 32'hF0000014;
  localparam logic [31:0] KEYSW_ADDR_KCTRL = 32'hF0000110;
  localparam logic [31:0] KEYSW_ADDR_SCTRL = 32'hF0000114;

  localparam int CTRL_READY = 0;
  localparam int CTRL_OVR   = 2;
  localparam int CTRL_IE    = 4;

  localparam int KEYSW_DEBOUNCE_DEFAULT = 50000;

  function automatic logic [31:0] ctrl_word(input logic ready, input logic ovr, input logic ie);
    logic [31:0] w;
    w = '0;
    w[CTRL_READY] = ready;
    w[CTRL_OVR]   = ovr;
    w[CTRL_IE]    = ie;
    return w;
  endfunction

endpackage

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - 2-flop synchroniser plus per-bit stability debouncer
// Purpose: accepts a raw input bit only after it has held a new value for
//          CYCLES consecutive synchronised samples (CYCLES >= 2).
// Ports:   clk, reset (async active-low), raw_i[WIDTH] raw pins,
//          accepted_o[WIDTH] debounced vector, changed_o pulse that is high
//          in the cycle whose posedge updates accepted_o.
module input_debouncer #(
  parameter int WIDTH  = 4,
  parameter int CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] accepted_o,
  output logic             changed_o
);

  localparam int CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;

  logic [WIDTH-1:0]         sync1_q, sync2_q;
  logic [WIDTH-1:0]         acc_q, acc_d;
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] != acc_q[i]) begin
        if (cnt_q[i] == CW'(CYCLES - 1)) begin
          acc_d[i] = sync2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end else begin
        // any sample agreeing with the accepted value restarts the count
        cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign accepted_o = acc_q;
  // combinational so status flags update on the same edge as the data
  assign changed_o  = (acc_d != acc_q);

endmodule

// File: rtl/keysw_io_ctrl.sv
// rtl/keysw_io_ctrl.sv - memory-mapped KEY/SW input peripheral on the shared data bus
// Purpose: debounced KEY (active-low pins, pressed = 1) and SW inputs exposed as
//          DATA and CTRL/status registers; optional interrupt under KEYSW_IRQ_EN.
// Ports:   clk, reset (async active-low), addr[DBITS], wrEn (1 = CPU drives bus),
//          memBus[DBITS] inout (driven only on a matching read),
//          keyRaw[KBITS], swRaw[SBITS], irq (only with KEYSW_IRQ_EN).
module keysw_io_ctrl
  import keysw_pkg::*;
#(
  parameter int                DBITS           = 32,
  parameter logic [DBITS-1:0]  ADDR_KDATA      = KEYSW_ADDR_KDATA,
  parameter logic [DBITS-1:0]  ADDR_SDATA      = KEYSW_ADDR_SDATA,
  parameter logic [DBITS-1:0]  ADDR_KCTRL      = KEYSW_ADDR_KCTRL,
  parameter logic [DBITS-1:0]  ADDR_SCTRL      = KEYSW_ADDR_SCTRL,
  parameter int                KBITS           = 4,
  parameter int                SBITS           = 10,
  parameter int                DEBOUNCE_CYCLES = KEYSW_DEBOUNCE_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] addr,
  input  logic             wrEn,
  inout  wire  [DBITS-1:0] memBus,
  input  logic [KBITS-1:0] keyRaw,
`ifdef KEYSW_IRQ_EN
  input  logic [SBITS-1:0] swRaw,
  output logic             irq
`else
  input  logic [SBITS-1:0] swRaw
`endif
);

  logic [KBITS-1:0] k_acc;
  logic [SBITS-1:0] s_acc;
  logic             k_chg, s_chg;

  input_debouncer #(.WIDTH(KBITS), .CYCLES(DEBOUNCE_CYCLES)) u_key_db (
    .clk       (clk),
    .reset     (reset),
    .raw_i     (~keyRaw),
    .accepted_o(k_acc),
    .changed_o (k_chg)
  );

  input_debouncer #(.WIDTH(SBITS), .CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
    .clk       (clk),
    .reset     (reset),
    .raw_i     (swRaw),
    .accepted_o(s_acc),
    .changed_o (s_chg)
  );

  logic hit_kdata, hit_sdata, hit_kctrl, hit_sctrl, rd_hit;
  logic rd_kdata, rd_sdata, wr_kctrl, wr_sctrl;

  assign hit_kdata = (addr == ADDR_KDATA);
  assign hit_sdata = (addr == ADDR_SDATA);
  assign hit_kctrl = (addr == ADDR_KCTRL);
  assign hit_sctrl = (addr == ADDR_SCTRL);
  assign rd_hit    = !wrEn && (hit_kdata || hit_sdata || hit_kctrl || hit_sctrl);
  assign rd_kdata  = !wrEn && hit_kdata;
  assign rd_sdata  = !wrEn && hit_sdata;
  assign wr_kctrl  = wrEn && hit_kctrl;
  assign wr_sctrl  = wrEn && hit_sctrl;

  logic k_rdy_q, k_rdy_d, k_ovr_q, k_ovr_d;
  logic s_rdy_q, s_rdy_d, s_ovr_q, s_ovr_d;
  logic k_ie, s_ie;

  always_comb begin
    k_rdy_d = k_rdy_q;
    k_ovr_d = k_ovr_q;
    s_rdy_d = s_rdy_q;
    s_ovr_d = s_ovr_q;
    // a new change always wins over a read-clear or write-clear of READY;
    // a change coinciding with the data read is not an overrun (old value consumed)
    if (k_chg)                              k_rdy_d = 1'b1;
    else if (rd_kdata)                      k_rdy_d = 1'b0;
    else if (wr_kctrl && !memBus[CTRL_READY]) k_rdy_d = 1'b0;
    if (k_chg && k_rdy_q && !rd_kdata)      k_ovr_d = 1'b1;
    else if (wr_kctrl && !memBus[CTRL_OVR]) k_ovr_d = 1'b0;

    if (s_chg)                              s_rdy_d = 1'b1;
    else if (rd_sdata)                      s_rdy_d = 1'b0;
    else if (wr_sctrl && !memBus[CTRL_READY]) s_rdy_d = 1'b0;
    if (s_chg && s_rdy_q && !rd_sdata)      s_ovr_d = 1'b1;
    else if (wr_sctrl && !memBus[CTRL_OVR]) s_ovr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_rdy_q <= 1'b0;
      k_ovr_q <= 1'b0;
      s_rdy_q <= 1'b0;
      s_ovr_q <= 1'b0;
    end else begin
      k_rdy_q <= k_rdy_d;
      k_ovr_q <= k_ovr_d;
      s_rdy_q <= s_rdy_d;
      s_ovr_q <= s_ovr_d;
    end
  end

`ifdef KEYSW_IRQ_EN
  logic k_ie_q, s_ie_q, irq_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_ie_q <= 1'b0;
      s_ie_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      if (wr_kctrl) k_ie_q <= memBus[CTRL_IE];
      if (wr_sctrl) s_ie_q <= memBus[CTRL_IE];
      irq_q <= (k_rdy_q & k_ie_q) | (s_rdy_q & s_ie_q);
    end
  end

  assign k_ie = k_ie_q;
  assign s_ie = s_ie_q;
  assign irq  = irq_q;
`else
  assign k_ie = 1'b0;
  assign s_ie = 1'b0;
`endif

  logic [DBITS-1:0] rdata;

  always_comb begin
    rdata = '0;
    if (hit_kdata)      rdata = DBITS'(k_acc);
    else if (hit_sdata) rdata = DBITS'(s_acc);
    else if (hit_kctrl) rdata = DBITS'(ctrl_word(k_rdy_q, k_ovr_q, k_ie));
    else if (hit_sctrl) rdata = DBITS'(ctrl_word(s_rdy_q, s_ovr_q, s_ie));
  end

  // bus released while in reset so a held reset never contends with the CPU
  assign memBus = (reset && rd_hit) ? rdata : {DBITS{1'bz}};

  logic unused_bus;
  assign unused_bus = ^memBus;

endmodule

// File: tb/tb_keysw_io_ctrl.sv
// tb/tb_keysw_io_ctrl.sv - directed table-driven bench for keysw_io_ctrl
module tb_keysw_io_ctrl;
  import keysw_pkg::*;

  localparam logic [31:0] IDLE  = 32'h0;
  localparam logic [31:0] UNMAP = 32'hF0000018;
  localparam logic [31:0] ZV    = 32'hFFFFFFFF;
`ifdef KEYSW_IRQ_EN
  localparam logic [31:0] IE_RB = 32'h10;
`else
  localparam logic [31:0] IE_RB = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        wrEn;
  logic [31:0] wdata;
  logic [3:0]  keyRaw;
  logic [9:0]  swRaw;
  wire  [31:0] memBus;
`ifdef KEYSW_IRQ_EN
  logic        irq;
`endif

  always #5 clk = ~clk;

  assign memBus = wrEn ? wdata : 32'hzzzzzzzz;
  // undriven bus lines read as 1
  for (genvar g = 0; g < 32; g++) begin : g_pu
    pullup (memBus[g]);
  end

  keysw_io_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .wrEn  (wrEn),
    .memBus(memBus),
    .keyRaw(keyRaw),
`ifdef KEYSW_IRQ_EN
    .swRaw (swRaw),
    .irq   (irq)
`else
    .swRaw (swRaw)
`endif
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] a;
    logic        wr;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[16];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // look at a register without letting a posedge see the address
  task automatic peek(input logic [31:0] a, input logic [31:0] exp, input string name);
    addr = a; wrEn = 1'b0;
    #1;
    check(name, memBus, exp);
    addr = IDLE;
  endtask

  // full read cycle: address held across one posedge
  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    addr = a; wrEn = 1'b0;
    #1;
    check(name, memBus, exp);
    @(negedge clk);
    addr = IDLE;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; wrEn = 1'b1;
    @(negedge clk);
    wrEn = 1'b0; addr = IDLE;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0]  = '{KEYSW_ADDR_KDATA, 1'b0, 32'h0, 32'h0};
    vt[1]  = '{KEYSW_ADDR_SDATA, 1'b0, 32'h0, 32'h0};
    vt[2]  = '{KEYSW_ADDR_KCTRL, 1'b0, 32'h0, 32'h0};
    vt[3]  = '{KEYSW_ADDR_SCTRL, 1'b0, 32'h0, 32'h0};
    vt[4]  = '{UNMAP,            1'b0, 32'h0, ZV};
    vt[5]  = '{KEYSW_ADDR_KDATA, 1'b1, ZV,    32'h0};
    vt[6]  = '{KEYSW_ADDR_KDATA, 1'b0, 32'h0, 32'h0};
    vt[7]  = '{KEYSW_ADDR_KCTRL, 1'b1, ZV,    32'h0};
    vt[8]  = '{KEYSW_ADDR_KCTRL, 1'b0, 32'h0, IE_RB};
    vt[9]  = '{KEYSW_ADDR_SCTRL, 1'b1, ZV,    32'h0};
    vt[10] = '{KEYSW_ADDR_SCTRL, 1'b0, 32'h0, IE_RB};
    vt[11] = '{KEYSW_ADDR_KCTRL, 1'b1, 32'h0, 32'h0};
    vt[12] = '{KEYSW_ADDR_SCTRL, 1'b1, 32'h0, 32'h0};
    vt[13] = '{KEYSW_ADDR_KCTRL, 1'b0, 32'h0, 32'h0};
    vt[14] = '{KEYSW_ADDR_SCTRL, 1'b0, 32'h0, 32'h0};
    vt[15] = '{32'h00000010,     1'b0, 32'h0, ZV};

    reset = 1'b0; addr = IDLE; wrEn = 1'b0; wdata = '0;
    keyRaw = 4'hF; swRaw = '0;
    repeat (2) @(negedge clk);
    peek(KEYSW_ADDR_KDATA, ZV, "bus_in_reset");
`ifdef KEYSW_IRQ_EN
    check("irq_in_reset", {31'b0, irq}, 32'h0);
`endif
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      if (vt[i].wr) wr(vt[i].a, vt[i].d);
      else          rd(vt[i].a, vt[i].exp, $sformatf("vec%0d", i));
    end

    // key held through reset: accepted 6 cycles after release
    reset = 1'b0; keyRaw = 4'b1110;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    rd(KEYSW_ADDR_KDATA, 32'h0, "kdata_pre_accept");
    peek(KEYSW_ADDR_KCTRL, 32'h1, "kctrl_after_release");
    rd(KEYSW_ADDR_KDATA, 32'h1, "kdata_pressed");
    peek(KEYSW_ADDR_KCTRL, 32'h0, "kctrl_read_clear");
    peek(UNMAP, ZV, "unmapped_z");

    // bounce rejection on swRaw[3]
    for (int i = 0; i < 10; i++) begin
      swRaw[3] = ~swRaw[3];
      repeat (2) @(negedge clk);
      peek(KEYSW_ADDR_SDATA, 32'h0, $sformatf("bounce%0d", i));
    end
    swRaw[3] = 1'b1;
    repeat (5) @(negedge clk);
    peek(KEYSW_ADDR_SDATA, 32'h0, "bounce_pre_accept");
    @(negedge clk);
    peek(KEYSW_ADDR_SDATA, 32'h8, "bounce_accept");

    // overrun: second change with READY still set
    swRaw[0] = 1'b1;
    repeat (6) @(negedge clk);
    peek(KEYSW_ADDR_SCTRL, 32'h5, "overrun_set");
    peek(KEYSW_ADDR_SDATA, 32'h9, "overrun_data");
    wr(KEYSW_ADDR_SCTRL, 32'hFFFFFFFB);
    peek(KEYSW_ADDR_SCTRL, 32'h1, "overrun_wclear");
    wr(KEYSW_ADDR_SCTRL, 32'hFFFFFFFE);
    peek(KEYSW_ADDR_SCTRL, 32'h0, "ready_wclear");

    // read-clear coincident with an accepted change, READY already 1
    swRaw[1] = 1'b1;
    repeat (6) @(negedge clk);
    peek(KEYSW_ADDR_SCTRL, 32'h1, "simul_ready_pre");
    swRaw[1] = 1'b0;
    repeat (5) @(negedge clk);
    rd(KEYSW_ADDR_SDATA, 32'hB, "simul_read");
    peek(KEYSW_ADDR_SCTRL, 32'h1, "simul_ctrl");
    peek(KEYSW_ADDR_SDATA, 32'h9, "simul_data");
    rd(UNMAP, ZV, "unmapped_no_effect_z");
    peek(KEYSW_ADDR_SCTRL, 32'h1, "unmapped_no_effect");
    rd(KEYSW_ADDR_SDATA, 32'h9, "sdata_read");
    peek(KEYSW_ADDR_SCTRL, 32'h0, "sdata_read_clear");

`ifdef KEYSW_IRQ_EN
    wr(KEYSW_ADDR_KCTRL, 32'h10);
    keyRaw = 4'b1100;
    repeat (5) @(negedge clk);
    peek(KEYSW_ADDR_KCTRL, 32'h10, "irq_ie_set");
    check("irq_idle", {31'b0, irq}, 32'h0);
    @(negedge clk);
    peek(KEYSW_ADDR_KCTRL, 32'h11, "irq_ready");
    check("irq_lag", {31'b0, irq}, 32'h0);
    @(negedge clk);
    check("irq_rise", {31'b0, irq}, 32'h1);
    rd(KEYSW_ADDR_KDATA, 32'h3, "irq_kdata");
    check("irq_hold", {31'b0, irq}, 32'h1);
    @(negedge clk);
    check("irq_drop", {31'b0, irq}, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keysw_io_ctrl.md
Name: keysw_io_ctrl

Overview:
- Memory-mapped input peripheral for the processor's shared data bus, directly upstream of the pipeline's memory stage.
- Synchronises and debounces the board KEY and SW inputs, then exposes them as device registers.
- Each input set gets a data register and a control/status register.
- Registers are serviced by the same address/write-enable/bidirectional-bus protocol the writeback stage uses for data memory and LED/HEX outputs.

Parameters:
- DBITS, 32, bus data and address width.
- ADDR_KDATA, 32'hF0000010, KEY data register (read-only).
- ADDR_SDATA, 32'hF0000014, SW data register (read-only).
- ADDR_KCTRL, 32'hF0000110, KEY control/status register.
- ADDR_SCTRL, 32'hF0000114, SW control/status register.
- KBITS, 4, number of keys.
- SBITS, 10, number of switches.
- DEBOUNCE_CYCLES, 16'd50000, cycles a raw input must stay stable before it is accepted (minimum 2).

Ports:
- clk  input  1  processor clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- addr  input  DBITS  bus address (pipeline ALU result).
- wrEn  input  1  bus write strobe; 1 = processor drives memBus.
- memBus  inout  DBITS  shared data bus; driven only during a matching read, otherwise high-Z.
- keyRaw  input  KBITS  raw KEY pins, active-low on the board; inverted internally so that pressed = 1.
- swRaw  input  SBITS  raw SW pins.

Behaviour:
- Synchronisation: each raw bit passes through a 2-flop synchroniser.
- Debounce:
  - One counter per bit. When the synchronised value differs from the accepted value, the counter increments; otherwise it clears.
  - When the counter reaches DEBOUNCE_CYCLES-1, the accepted bit takes the new value and the counter clears.
  - Latency from a stable pin change to the data-register update is 2 + DEBOUNCE_CYCLES cycles.
- Data registers:
  - KDATA = {zero, kAccepted}; SDATA = {zero, sAccepted}.
  - Unused upper bits always read 0.
- CTRL register bits:
  - bit0 READY: sticky; sets on any cycle where the accepted vector changes.
  - bit2 OVERRUN: sticky; sets when the accepted vector changes while READY is already 1.
  - All other bits read 0.
- Read cycle:
  - A read is wrEn=0 with addr equal to one of the four addresses. memBus is driven combinationally that cycle.
  - A KDATA or SDATA read clears the matching READY at the next posedge.
  - If READY would set on that same posedge, the set wins: READY stays 1 and OVERRUN is not set.
- Write cycle:
  - wrEn=1 to a CTRL address: writing 0 to bit0 or bit2 clears that bit; writing 1 leaves it unchanged.
  - Writes to the DATA addresses are ignored.
  - If a write-clear of OVERRUN coincides with a new overrun event, OVERRUN stays 1.
- Non-matching addresses: memBus is high-Z and there are no side effects.
- Reset (asynchronous):
  - Synchronisers, counters, accepted vectors, READY and OVERRUN all go to 0.
  - memBus goes high-Z.
  - A debounce in progress is discarded.
- Release: the first post-reset accepted value takes full debounce time. With a key held through reset, KDATA shows it pressed DEBOUNCE_CYCLES+2 cycles after release, and READY sets.

Optional Feature:
- Macro: KEYSW_IRQ_EN.
- When defined:
  - Adds output irq (1 bit).
  - Adds CTRL bit4 IE (read/write; written directly, not write-0-to-clear; reset 0).
  - irq is registered: irq = (KCTRL.READY & KCTRL.IE) | (SCTRL.READY & SCTRL.IE), resets to 0, and is one cycle behind the status bits.
- When not defined: no irq port, and bit4 reads 0 with writes ignored.

Decomposition:
- Shared package keysw_pkg:
  - The four address constants.
  - CTRL bit positions READY=0, OVERRUN=2, IE=4.
  - Default DEBOUNCE_CYCLES.
- Sub-module input_debouncer #(WIDTH, CYCLES):
  - Contains the synchroniser, per-bit counters and accepted vector.
  - Outputs accepted[WIDTH] and a one-cycle changed pulse.
  - Instantiated twice, once for KEY and once for SW.
- Top level holds the status logic, bus decode and tristate driver.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset pulse: hold reset=0 with keyRaw=4'b1110, then release. After 6 cycles, a KDATA read returns 32'h1 and a KCTRL read returns 32'h1.
- Bounce rejection: toggle swRaw[3] every 2 cycles for 20 cycles, then hold at 1. SDATA stays 0 until 6 cycles after the final edge, then reads 32'h8.
- Read-clear: with READY=1, read KDATA. Next cycle KCTRL reads 32'h0. A read of an unmapped address (32'hF0000018) leaves memBus high-Z.
- Overrun: two accepted SW changes with no read between them. SCTRL reads 32'h5. Write 32'hFFFFFFFB to SCTRL, then SCTRL reads 32'h1.
- Simultaneous events: read-clear of READY on the same posedge that a change is accepted. READY stays 1 and OVERRUN stays 0.
- With KEYSW_IRQ_EN: write 32'h10 to KCTRL, then accept a key press. irq rises one cycle after READY. Reading KDATA drops irq two cycles after the read.
